// File: rtl/reg_pipe_pkg.sv
// Shared helpers for the reg_pipe elastic pipeline register.
package reg_pipe_pkg;

  // Ceiling log2 that elaborates to a constant; clog2(1) = 0, clog2(4) = 2, clog2(5) = 3.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/reg_pipe_stage.sv
// One pipeline slot: a valid bit and its payload. The top decides when the
// slot loads; reset and flush both empty it and zero the payload.
module reg_pipe_stage
  import reg_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rsth,
  input  logic                  clrh,
  input  logic                  load_i,
  input  logic                  v_i,
  input  logic [DATA_WIDTH-1:0] d_i,
  output logic                  v_o,
  output logic [DATA_WIDTH-1:0] d_o
);

  logic                  v_q, v_d;
  logic [DATA_WIDTH-1:0] d_q, d_d;

  // Next state: take the predecessor's valid on load, but only overwrite the
  // payload when a real word arrives so bubbles leave stale data in place.
  always_comb begin
    // NOTE: every output gets a default before the ifs, so no path leaves a latch.
    v_d = v_q;
    d_d = d_q;
    if (load_i) begin
      v_d = v_i;
      if (v_i) d_d = d_i;
    end
  end

  // State register with reset taking priority over flush over normal load.
  always_ff @(posedge clk) begin
    // NOTE: the payload is reset too, because data_o must read zero after reset or flush.
    if (rsth || clrh) begin
      v_q <= 1'b0;
      d_q <= '0;
    end else begin
      // NOTE: non-blocking so every stage samples its predecessor's pre-edge value.
      v_q <= v_d;
      d_q <= d_d;
    end
  end

  assign v_o = v_q;
  assign d_o = d_q;

endmodule

// File: rtl/reg_pipe.sv
// Elastic pipeline register: DEPTH valid/ready stages with bubble collapsing,
// synchronous flush and a global enable that freezes the whole pipe.
module reg_pipe
  import reg_pipe_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 2,
  localparam int CNT_W      = clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rsth,
  input  logic                  clrh,
  input  logic                  enh,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [CNT_W-1:0]      count_o
);

  if (DEPTH < 1 || DATA_WIDTH < 1) begin : g_param_check
    $error("reg_pipe: DEPTH and DATA_WIDTH must both be >= 1");
  end

  logic [DEPTH-1:0]      v;
  logic [DEPTH-1:0]      adv;
  logic [DATA_WIDTH-1:0] d [DEPTH];
  logic [CNT_W-1:0]      cnt;

  // Advance chain: a stage may load if it is empty or its successor moves on.
  // This is the only combinational path from ready_i to ready_o.
  always_comb begin
    adv          = '0;
    adv[DEPTH-1] = ready_i | ~v[DEPTH-1];
    for (int k = DEPTH - 2; k >= 0; k--) begin
      adv[k] = ~v[k] | adv[k+1];
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic                  v_in;
    logic [DATA_WIDTH-1:0] d_in;

    if (k == 0) begin : g_head
      assign v_in = valid_i;
      assign d_in = data_i;
    end else begin : g_body
      assign v_in = v[k-1];
      assign d_in = d[k-1];
    end

    reg_pipe_stage #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_stage (
      .clk   (clk),
      .rsth  (rsth),
      .clrh  (clrh),
      .load_i(enh & adv[k]),
      .v_i   (v_in),
      .d_i   (d_in),
      .v_o   (v[k]),
      .d_o   (d[k])
    );
  end

  // Occupancy: population count of the stage valid bits.
  always_comb begin
    cnt = '0;
    for (int k = 0; k < DEPTH; k++) begin
      cnt = cnt + CNT_W'(v[k]);
    end
  end

  assign ready_o = enh & adv[0];
  assign valid_o = enh & v[DEPTH-1];
  assign data_o  = d[DEPTH-1];
  assign count_o = cnt;

endmodule
